// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I core: sequences each instruction through its
// states and drives datapath selects/enables. State codes: FETCH=0 DECODE=1 MEMADR=2
// MEMREAD=3 MEMWB=4 MEMWRITE=5 EXECR=6 EXECI=7 ALUWB=8 BRANCH=9 JAL=10 JALR_EX=11
// JALR_PC=12 LUI=13; codes 14-15 are unreachable and return to FETCH.
module multicycle_controller #(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        instr,
  input  logic               Zero,
  input  logic               cout,
  input  logic               overflow,
  input  logic               sign,
  output logic [2:0]         ImmSrc,
  output logic [3:0]         ALUControl,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               AdrSrc,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               retire,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR_EX  = 4'd11,
    S_JALR_PC  = 4'd12,
    S_LUI      = 4'd13
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  state_e     state_q;
  state_e     state_d;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       taken;
  logic       unused_instr_bits;

  assign op       = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7b5 = instr[30];
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};
  assign state    = STATE_W'(state_q);

  // funct3 -> ALU op; subtract only applies to register-register add
  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic f7b5,
                                            input logic is_r);
    logic [3:0] code;
    case (f3)
      3'b000:  code = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Branch condition from the A-B flags
  always_comb begin
    case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = ~Zero;
      3'b100:  taken = sign ^ overflow;
      3'b101:  taken = ~(sign ^ overflow);
      3'b110:  taken = ~cout;
      3'b111:  taken = cout;
      default: taken = 1'b0;
    endcase
  end

  // Immediate format; instr is stale during FETCH so it is ignored there
  always_comb begin
    ImmSrc = 3'b000;
    if (state_q != S_FETCH) begin
      case (op)
        OP_STORE:         ImmSrc = 3'b001;
        OP_BRANCH:        ImmSrc = 3'b010;
        OP_LUI, OP_AUIPC: ImmSrc = 3'b011;
        OP_JAL:           ImmSrc = 3'b100;
        default:          ImmSrc = 3'b000;
      endcase
    end
  end

  always_comb begin
    state_d    = S_FETCH;
    ALUControl = ALU_ADD;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR_EX;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_ALUWB;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        retire    = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        retire   = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_decode(funct3, funct7b5, 1'b1);
        state_d    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_decode(funct3, funct7b5, 1'b0);
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        PCWrite    = taken;
        retire     = 1'b1;
      end
      S_JAL, S_JALR_PC: begin
        // PC takes the target held in ALUOut while ALUOut captures the link address
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        state_d = S_ALUWB;
      end
      S_JALR_EX: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = S_JALR_PC;
      end
      S_LUI: begin
        ResultSrc = 2'b11;
        RegWrite  = 1'b1;
        retire    = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    // A reset cycle abandons the instruction without any write
    if (reset) begin
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      retire   = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed cases plus random instruction
// streams with random ALU flags and random reset aborts, against a step-sequence model.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        Zero, cout, overflow, sign;
  logic [2:0]  ImmSrc;
  logic [3:0]  ALUControl;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
  logic        AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, retire, illegal;
  logic [3:0]  state;

  multicycle_controller #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .instr(instr),
    .Zero(Zero), .cout(cout), .overflow(overflow), .sign(sign),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .AdrSrc(AdrSrc),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .retire(retire), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  typedef enum {ST_F, ST_D, ST_MA, ST_MR, ST_MWB, ST_MW, ST_ER, ST_EI, ST_WB,
                ST_BR, ST_J, ST_JX, ST_JP, ST_LUI} step_e;

  typedef struct {
    logic [1:0] a, b, res;
    logic       adr, irw, pcw, rw, mw, ret, ill;
    logic [3:0] alu;
  } exp_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  step_e plan[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Sequence of steps an instruction walks through, one entry per clock cycle
  function automatic void build_plan(input logic [31:0] ins);
    plan = '{ST_F, ST_D};
    case (ins[6:0])
      7'b0000011: plan = {plan, ST_MA, ST_MR, ST_MWB};
      7'b0100011: plan = {plan, ST_MA, ST_MW};
      7'b0110011: plan = {plan, ST_ER, ST_WB};
      7'b0010011: plan = {plan, ST_EI, ST_WB};
      7'b1100011: plan = {plan, ST_BR};
      7'b1101111: plan = {plan, ST_J, ST_WB};
      7'b1100111: plan = {plan, ST_JX, ST_JP, ST_WB};
      7'b0110111: plan = {plan, ST_LUI};
      7'b0010111: plan = {plan, ST_WB};
      default: ;
    endcase
  endfunction

  function automatic logic [3:0] exp_alu(input logic [31:0] ins, input bit is_r);
    case (ins[14:12])
      3'd0: return (is_r && ins[30]) ? 4'd1 : 4'd0;
      3'd1: return 4'd7;
      3'd2: return 4'd5;
      3'd3: return 4'd6;
      3'd4: return 4'd4;
      3'd5: return ins[30] ? 4'd9 : 4'd8;
      3'd6: return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  function automatic logic [2:0] exp_imm(input logic [6:0] op);
    case (op)
      7'b0100011:             return 3'd1;
      7'b1100011:             return 3'd2;
      7'b0110111, 7'b0010111: return 3'd3;
      7'b1101111:             return 3'd4;
      default:                return 3'd0;
    endcase
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic z, input logic c,
                                    input logic v, input logic n);
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return n ^ v;
      3'd5: return !(n ^ v);
      3'd6: return !c;
      3'd7: return c;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t expect_for(input step_e s, input logic [31:0] ins);
    exp_t e = '{a: 2'b00, b: 2'b00, res: 2'b00, adr: 1'b0, irw: 1'b0, pcw: 1'b0,
                rw: 1'b0, mw: 1'b0, ret: 1'b0, ill: 1'b0, alu: 4'd0};
    case (s)
      ST_F:   begin e.irw = 1; e.b = 2'b10; e.res = 2'b10; e.pcw = 1; end
      ST_D:   begin e.a = 2'b01; e.b = 2'b01; e.ill = !is_legal(ins[6:0]); end
      ST_MA, ST_JX: begin e.a = 2'b10; e.b = 2'b01; end
      ST_MR:  e.adr = 1;
      ST_MWB: begin e.res = 2'b01; e.rw = 1; e.ret = 1; end
      ST_MW:  begin e.adr = 1; e.mw = 1; e.ret = 1; end
      ST_ER:  begin e.a = 2'b10; e.alu = exp_alu(ins, 1); end
      ST_EI:  begin e.a = 2'b10; e.b = 2'b01; e.alu = exp_alu(ins, 0); end
      ST_WB:  begin e.rw = 1; e.ret = 1; end
      ST_BR:  begin
        e.a = 2'b10; e.alu = 4'd1; e.ret = 1;
        e.pcw = br_taken(ins[14:12], Zero, cout, overflow, sign);
      end
      ST_J, ST_JP: begin e.a = 2'b01; e.b = 2'b10; e.pcw = 1; end
      ST_LUI: begin e.res = 2'b11; e.rw = 1; e.ret = 1; end
      default: ;
    endcase
    return e;
  endfunction

  // Runs one instruction from its FETCH cycle; abort_at asserts reset in that step
  task automatic run_instr(input logic [31:0] ins, input bit rnd_flags,
                           input logic [3:0] flags, input int abort_at);
    exp_t e;
    logic [3:0] fl;
    build_plan(ins);
    for (int i = 0; i < plan.size(); i++) begin
      instr = (plan[i] == ST_F) ? $urandom : ins;
      fl = rnd_flags ? 4'($urandom) : flags;
      {Zero, cout, overflow, sign} = fl;
      reset = (i == abort_at);
      @(negedge clk);
      e = expect_for(plan[i], ins);
      if (reset) begin
        {e.irw, e.pcw, e.rw, e.mw, e.ret, e.ill} = 6'b0;
      end else begin
        check($sformatf("mux[%s]", plan[i].name()),
              32'({ALUSrcA, ALUSrcB, ResultSrc, AdrSrc}),
              32'({e.a, e.b, e.res, e.adr}));
      end
      check($sformatf("en[%s]", plan[i].name()),
            32'({IRWrite, PCWrite, RegWrite, MemWrite, retire, illegal}),
            32'({e.irw, e.pcw, e.rw, e.mw, e.ret, e.ill}));
      check($sformatf("alu[%s]", plan[i].name()), 32'(ALUControl), 32'(e.alu));
      check($sformatf("is_fetch[%s]", plan[i].name()), 32'(state == 4'd0),
            32'(plan[i] == ST_F));
      if (plan[i] != ST_F && is_legal(ins[6:0]))
        check($sformatf("imm[%s]", plan[i].name()), 32'(ImmSrc), 32'(exp_imm(ins[6:0])));
      @(posedge clk);
      #1;
      if (i == abort_at) begin
        reset = 1'b0;
        return;
      end
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom;
    logic [6:0]  ops[9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    int k = $urandom_range(0, 9);
    if (k < 9) begin
      r[6:0] = ops[k];
    end else begin
      do r[6:0] = 7'($urandom); while (is_legal(r[6:0]));
    end
    return r;
  endfunction

  initial begin
    logic [31:0] ins;
    int          ab;
    reset = 1'b1;
    instr = 32'h0;
    {Zero, cout, overflow, sign} = 4'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      instr = $urandom;
      @(negedge clk);
      check("reset_en", 32'({IRWrite, PCWrite, RegWrite, MemWrite, retire, illegal}), 32'h0);
      check("reset_state", 32'(state), 32'h0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;

    run_instr(32'h00A00093, 1, 4'b0, -1);   // addi
    run_instr(32'h40208133, 1, 4'b0, -1);   // sub
    run_instr(32'h4020D113, 1, 4'b0, -1);   // srai
    run_instr(32'h0000A103, 1, 4'b0, -1);   // lw
    run_instr(32'h0020A023, 1, 4'b0, -1);   // sw
    run_instr(32'h00000063, 0, 4'b1000, -1); // beq taken
    run_instr(32'h00000063, 0, 4'b0000, -1); // beq not taken
    run_instr(32'h00004063, 0, 4'b0011, -1); // blt sign=ovf=1
    run_instr(32'h0000007F, 1, 4'b0, -1);   // illegal
    run_instr(32'h0020A023, 1, 4'b0, 3);    // reset during MEMWRITE
    run_instr(32'h000000EF, 1, 4'b0, -1);   // jal
    run_instr(32'h000080E7, 1, 4'b0, -1);   // jalr
    run_instr(32'h123450B7, 1, 4'b0, -1);   // lui
    run_instr(32'h00001097, 1, 4'b0, -1);   // auipc

    for (int n = 0; n < 300; n++) begin
      ins = rand_instr();
      build_plan(ins);
      ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, plan.size() - 1) : -1;
      run_instr(ins, 1, 4'b0, ab);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM for the multicycle RV32I core. It sits directly upstream of the datapath and drives every datapath select and enable (ImmSrc, ALUControl, ResultSrc, IRWrite, RegWrite, ALUSrcA/B, AdrSrc, PCWrite), plus MemWrite to memory. It decodes the latched instruction register and evaluates branch conditions from the ALU flags. All outputs are Moore-style per state, except the ALUControl/ImmSrc decode and the branch-taken PCWrite.

## Interface
- STATE_W, 4, width of state register and debug port

- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- instr  in  32  latched instruction (datapath IR); uses op=[6:0], funct3=[14:12], funct7b5=[30]
- Zero, cout, overflow, sign  in  1 each  ALU flags for current-cycle ALU op
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 U, 100 J; combinational from op
- ALUControl  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 A
- ALUSrcB  out  2  00 WriteData, 01 ImmExt, 10 constant 4
- AdrSrc  out  1  0 PC, 1 Result
- IRWrite, PCWrite, RegWrite, MemWrite  out  1 each  enables
- retire  out  1  one-cycle pulse on an instruction's final state
- illegal  out  1  one-cycle pulse on an unsupported opcode in DECODE
- state  out  STATE_W  current state, for debug

## Operation
- Unlisted outputs are 0/00 in every state; ALUControl defaults to add.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, PCWrite=1. Next state: DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, add; ALUOut receives OldPC+imm.
  - op 0000011/0100011 -> MEMADR
  - 0110011 -> EXECR; 0010011 -> EXECI
  - 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR_EX
  - 0110111 -> LUI; 0010111 -> ALUWB (AUIPC result already in ALUOut)
  - any other op -> FETCH, with illegal=1
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next: MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Next: MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, retire. Next: FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, retire. Next: FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALU op from funct3. Next: ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALU op from funct3. Next: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, retire. Next: FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=taken, retire. Next: FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. PC receives the DECODE target; ALUOut receives OldPC+4. Next: ALUWB.
- JALR_EX: ALUSrcA=10, ALUSrcB=01, add. Next: JALR_PC.
- JALR_PC: same outputs as JAL. Next: ALUWB. Target LSB is not cleared.
- LUI: ResultSrc=11, RegWrite=1, retire. Next: FETCH.
- funct3 decode, for EXECR and EXECI:
  - 000: sub only if EXECR and funct7b5=1, else add
  - 001 sll; 010 slt; 011 sltu; 100 xor
  - 101: sra if funct7b5=1, else srl
  - 110 or; 111 and
- Branch taken, evaluated on the A-B flags:
  - beq: Zero; bne: !Zero
  - blt: sign^overflow; bge: !(sign^overflow)
  - bltu: !cout; bgeu: cout
  - funct3 010/011 are never taken

## Timing
- Cycles per instruction:
  - lw 5, sw 4, R/I-ALU 4
  - branch 3, jal 4, jalr 5
  - lui 3, auipc 3
- Reset:
  - While reset=1, all enables (IRWrite, PCWrite, RegWrite, MemWrite) and retire/illegal are forced to 0.
  - The state register loads FETCH on a clock edge with reset=1.
  - The first cycle after reset deasserts is FETCH.
- Reset mid-instruction: the instruction is abandoned and no write occurs in the reset cycle. Earlier-cycle writes (e.g. PC update in FETCH) are not undone.
- instr is only valid from DECODE onward. FETCH outputs never depend on instr.
- ImmSrc and ALUControl are combinational from instr and state; no added latency.
- state encoding: FETCH=0. Other encodings are free, but must be documented in the RTL header.
- Unreachable state codes go to FETCH on the next edge with all enables 0.

## Test plan
- Reset held 3 cycles, then released: state=FETCH, PCWrite=1, IRWrite=1 on the first cycle; all enables 0 during reset.
- instr=0x00A00093 (addi x1,x0,10): states FETCH, DECODE, EXECI, ALUWB; ImmSrc=000, ALUSrcB=01; RegWrite=1 and retire=1 only in ALUWB.
- instr=0x40208133 (sub): ALUControl=0001 in EXECR. instr=0x4020D113 (srai): ALUControl=1001.
- lw 0x0000A103 takes 5 cycles with AdrSrc=1 in MEMREAD. sw 0x0020A023 takes 4 cycles with MemWrite=1 exactly once.
- beq with Zero=1: PCWrite=1 in BRANCH. Zero=0: PCWrite=0. blt with sign=1, overflow=1: not taken.
- instr=0x0000007F: illegal=1 in DECODE, next state FETCH, no RegWrite or MemWrite. Reset asserted during MEMWRITE: MemWrite=0, next state FETCH.
